// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reset_sequencer_seq_timer.sv
// Interval counter: tick marks the last cycle of a DELAY-cycle interval.
module seq_timer #(
    parameter int CNT_W = 8,
    parameter int DELAY = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign tick = (r_count == CNT_W'(DELAY - 1));

endmodule

// File: rtl/reset_sequencer.sv
// Staged clear generator: holds all domains in clear, then releases them in index order.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NSTAGES = 4,
    parameter int DELAY   = 16,
    parameter int CNT_W   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ext_hold,
    input  logic                             req,
    output logic [NSTAGES-1:0]               stage_clr,
    output logic [clog2(NSTAGES+1)-1:0]      stage_idx,
    output logic                             done
);

    localparam int IDX_W = clog2(NSTAGES + 1);

    generate
        if (NSTAGES < 1 || NSTAGES > 16) begin : g_bad_nstages
            $error("reset_sequencer: NSTAGES must be in 1..16");
        end
        if (DELAY < 1 || DELAY > (2 ** CNT_W) - 1) begin : g_bad_delay
            $error("reset_sequencer: DELAY must be >= 1 and fit in CNT_W bits");
        end
    endgenerate

    state_e             r_state;
    state_e             w_state_nxt;
    logic [NSTAGES-1:0] r_stage_clr;
    logic [NSTAGES-1:0] w_stage_clr_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_tmr_clr;
    logic               w_tmr_en;
    logic               w_tick;

    seq_timer #(
        .CNT_W (CNT_W),
        .DELAY (DELAY)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_tmr_clr),
        .en   (w_tmr_en),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ASSERT;
            r_stage_clr <= '1;
            r_idx       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stage_clr <= w_stage_clr_nxt;
            r_idx       <= w_idx_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Releases drop the lowest still-asserted bit, so shifting in a zero keeps index order.
    always_comb begin
        w_state_nxt     = r_state;
        w_stage_clr_nxt = r_stage_clr;
        w_idx_nxt       = r_idx;
        w_done_nxt      = r_done;
        w_tmr_clr       = 1'b0;
        w_tmr_en        = 1'b0;

        if (ext_hold || req) begin
            w_state_nxt     = ST_ASSERT;
            w_stage_clr_nxt = '1;
            w_idx_nxt       = '0;
            w_done_nxt      = 1'b0;
            w_tmr_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    w_tmr_en = 1'b1;
                    if (w_tick) begin
                        w_tmr_clr       = 1'b1;
                        w_stage_clr_nxt = r_stage_clr << 1;
                        w_idx_nxt       = IDX_W'(1);
                        w_state_nxt     = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    w_tmr_en = 1'b1;
                    if (w_tick) begin
                        w_tmr_clr = 1'b1;
                        if (r_idx < IDX_W'(NSTAGES)) begin
                            w_stage_clr_nxt = r_stage_clr << 1;
                            w_idx_nxt       = r_idx + IDX_W'(1);
                        end else begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    w_tmr_clr = 1'b1;
                end
                default: begin
                    w_state_nxt     = ST_ASSERT;
                    w_stage_clr_nxt = '1;
                    w_idx_nxt       = '0;
                    w_done_nxt      = 1'b0;
                    w_tmr_clr       = 1'b1;
                end
            endcase
        end
    end

    assign stage_clr = r_stage_clr;
    assign stage_idx = r_idx;
    assign done      = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default config plus the NSTAGES=1/DELAY=1 corner.
module tb_reset_sequencer;

    logic       clk;
    logic       rst, ext_hold, req;
    logic [3:0] stage_clr;
    logic [2:0] stage_idx;
    logic       done;

    logic       rst1, ext_hold1, req1;
    logic [0:0] stage_clr1;
    logic [0:0] stage_idx1;
    logic       done1;

    int n_checks;
    int n_errors;

    reset_sequencer #(.NSTAGES(4), .DELAY(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .ext_hold  (ext_hold),
        .req       (req),
        .stage_clr (stage_clr),
        .stage_idx (stage_idx),
        .done      (done)
    );

    reset_sequencer #(.NSTAGES(1), .DELAY(1), .CNT_W(8)) dut1 (
        .clk       (clk),
        .rst       (rst1),
        .ext_hold  (ext_hold1),
        .req       (req1),
        .stage_clr (stage_clr1),
        .stage_idx (stage_idx1),
        .done      (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_clr"},  32'(stage_clr), 32'hF);
        chk({tag, "_idx"},  32'(stage_idx), 32'd0);
        chk({tag, "_done"}, 32'(done),      32'd0);
    endtask

    // Walk 80 edges from an interval start; releases every 16 edges, done at 80.
    task automatic run_seq(input string tag);
        int k;
        logic [3:0] exp_clr;
        for (int e = 1; e <= 80; e++) begin
            step();
            k = e / 16;
            if (k > 4) k = 4;
            exp_clr = 4'hF << k;
            chk($sformatf("%s_clr_e%0d", tag, e),  32'(stage_clr), 32'(exp_clr));
            chk($sformatf("%s_idx_e%0d", tag, e),  32'(stage_idx), 32'(k));
            chk($sformatf("%s_done_e%0d", tag, e), 32'(done),      32'(e >= 80));
        end
    endtask

    logic [3:0] prev_clr;
    logic       mon_en;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("one_release_per_edge", 32'($countones(prev_clr & ~stage_clr) <= 1), 32'd1);
            assert ($countones(prev_clr & ~stage_clr) <= 1);
        end
        prev_clr = stage_clr;
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;
        rst = 1'b1; ext_hold = 1'b0; req = 1'b0;
        rst1 = 1'b1; ext_hold1 = 1'b0; req1 = 1'b0;

        // Power-up
        repeat (3) step();
        chk_reset_state("por");
        mon_en = 1'b1;
        rst = 1'b0;
        run_seq("pwrup");

        // Hold for 100 cycles after reset
        rst = 1'b1;
        step();
        chk_reset_state("hold_rst");
        rst = 1'b0;
        ext_hold = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("hold_clr", 32'(stage_clr), 32'hF);
        end
        chk("hold_idx", 32'(stage_idx), 32'd0);
        ext_hold = 1'b0;
        run_seq("hold");

        // Warm reset from RUN
        repeat (20) step();
        chk("run_done_held", 32'(done), 32'd1);
        chk("run_clr_held",  32'(stage_clr), 32'h0);
        req = 1'b1;
        step();
        req = 1'b0;
        chk_reset_state("warm");
        run_seq("warm");

        // Restart while two stages are released
        req = 1'b1;
        step();
        req = 1'b0;
        repeat (37) step();
        chk("mid_idx", 32'(stage_idx), 32'd2);
        chk("mid_clr", 32'(stage_clr), 32'hC);
        req = 1'b1;
        step();
        req = 1'b0;
        chk_reset_state("mid");
        run_seq("mid");

        // rst beats req and ext_hold; then hold+req behaves as hold
        rst = 1'b1; req = 1'b1; ext_hold = 1'b1;
        step();
        chk_reset_state("prio_rst");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("prio_hold_req_clr", 32'(stage_clr), 32'hF);
        end
        req = 1'b0;
        repeat (10) step();
        chk_reset_state("prio_hold");
        ext_hold = 1'b0;
        run_seq("prio");

        // NSTAGES=1, DELAY=1 corner
        step();
        chk("c1_rst_clr",  32'(stage_clr1), 32'd1);
        chk("c1_rst_done", 32'(done1),      32'd0);
        rst1 = 1'b0;
        step();
        chk("c1_e1_clr",  32'(stage_clr1), 32'd0);
        chk("c1_e1_idx",  32'(stage_idx1), 32'd1);
        chk("c1_e1_done", 32'(done1),      32'd0);
        step();
        chk("c1_e2_done", 32'(done1),      32'd1);
        req1 = 1'b1;
        step();
        req1 = 1'b0;
        chk("c1_req_clr",  32'(stage_clr1), 32'd1);
        chk("c1_req_done", 32'(done1),      32'd0);
        step();
        chk("c1_req_e1_clr", 32'(stage_clr1), 32'd0);
        step();
        chk("c1_req_e2_done", 32'(done1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
